// File: rtl/dsm_pkg.sv
// Shared definitions for the delta-sigma modulator datapath blocks.
//   coef_t        : coefficient word layout {en, neg, k[3:0]} (k signed)
//   acc_w()       : exact accumulator width for a shift-add FIR
//   sat_wrap()    : clamp or pass-through (caller truncates to width)
//   out_of_range(): value does not fit a w-bit two's complement word
// Values are carried as 64-bit signed, so accumulators must stay <= 64 bits.
package dsm_pkg;

  localparam int COEF_W = 6;
  localparam int K_W    = 4;

  typedef struct packed {
    logic           en;
    logic           neg;
    logic [K_W-1:0] k;    // signed shift, -8..+7
  } coef_t;

  // +8 covers a left shift of up to 7 plus negating the most negative input;
  // clog2(taps) covers the growth from summing all taps.
  function automatic int acc_w(input int width, input int taps);
    return width + 8 + $clog2(taps);
  endfunction

  function automatic logic out_of_range(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) || (v < lo);
  endfunction

  // With sat=0 the value is returned unchanged; the caller keeps the low w
  // bits, which is the wrap behaviour.
  function automatic logic signed [63:0] sat_wrap(input logic signed [63:0] v,
                                                   input int w, input bit sat);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r  = v;
    if (sat) begin
      if (v > hi)      r = hi;
      else if (v < lo) r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/h_fir_shiftadd_shift_term.sv
// shift_term: one power-of-two FIR tap, purely combinational.
//   x_i    : WIDTH-bit signed delayed sample
//   en_i   : tap enable (0 -> term is 0)
//   neg_i  : negate the shifted value
//   k_i    : signed shift, k>=0 left shift, k<0 arithmetic right shift (floor)
//   term_o : ACC_W-bit signed term
module shift_term
  import dsm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 26
) (
  input  logic signed [WIDTH-1:0] x_i,
  input  logic                    en_i,
  input  logic                    neg_i,
  input  logic signed [K_W-1:0]   k_i,
  output logic signed [ACC_W-1:0] term_o
);

  logic signed [ACC_W-1:0] ext, shf;
  logic        [K_W-1:0]   mag;

  always_comb begin
    ext = ACC_W'(x_i);
    // |k| for k=-8 is 8, which still fits the unsigned K_W-bit magnitude
    mag = k_i[K_W-1] ? K_W'(-k_i) : K_W'(k_i);
    shf = k_i[K_W-1] ? (ext >>> mag) : (ext <<< mag);
    if (!en_i)      term_o = '0;
    else if (neg_i) term_o = -shf;
    else            term_o = shf;
  end

endmodule

// File: rtl/h_fir_shiftadd.sv
// h_fir_shiftadd: strictly causal programmable shift-and-add FIR.
//   CLK, reset        : clock, async active-high reset
//   clr               : sync clear of delay line, pipeline, ovf (coefs kept)
//   in, in_valid      : sample x[n] and its strobe
//   coef_we/addr/data : coefficient bank write port ({en,neg,k})
//   out, out_valid    : saturated/wrapped y and its one-cycle strobe
//   ovf               : sticky "sum left the WIDTH range" flag
// y is computed from x[n-1]..x[n-TAPS], i.e. the delay line before the
// in_valid shift. PIPE=1 registers pairwise tap sums before the final add.
module h_fir_shiftadd
  import dsm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAPS  = 4,
  parameter int PIPE  = 0,
  parameter int SAT   = 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         in,
  input  logic                     in_valid,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic                     ovf
);

  localparam int ACC_W = acc_w(WIDTH, TAPS);

  logic [TAPS-1:0][WIDTH-1:0] d_q;
  coef_t [TAPS-1:0]           coef_q;
  logic signed [ACC_W-1:0]    term [TAPS];
  logic signed [ACC_W-1:0]    sum_fin;
  logic                       fire;
  logic [WIDTH-1:0]           out_d, out_q;
  logic                       out_valid_q, ovf_q, oor;

  // Coefficient bank; a computation in the write cycle still sees old values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) coef_q <= '0;
    else if (coef_we && (int'(coef_addr) < TAPS)) coef_q[coef_addr] <= coef_t'(coef_data);
  end

  // Delay line: d[0] = x[n-1]; clr wins over in_valid.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)  d_q <= '0;
    else if (clr) d_q <= '0;
    else if (in_valid) begin
      d_q[0] <= in;
      for (int i = 1; i < TAPS; i++) d_q[i] <= d_q[i-1];
    end
  end

  for (genvar i = 0; i < TAPS; i++) begin : g_tap
    shift_term #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_term (
      .x_i    (d_q[i]),
      .en_i   (coef_q[i].en),
      .neg_i  (coef_q[i].neg),
      .k_i    (coef_q[i].k),
      .term_o (term[i])
    );
  end

  if (PIPE != 0) begin : g_pipe
    localparam int NP = (TAPS + 1) / 2;
    logic signed [ACC_W-1:0] ps_d [NP];
    logic signed [ACC_W-1:0] ps_q [NP];
    logic                    s1_vld_q;

    for (genvar j = 0; j < NP; j++) begin : g_pair
      if (2*j + 1 < TAPS) begin : g_two
        assign ps_d[j] = term[2*j] + term[2*j+1];
      end else begin : g_one
        assign ps_d[j] = term[2*j];
      end
    end

    // clr drops any in-flight pair sums so nothing reaches the output.
    always_ff @(posedge CLK or posedge reset) begin
      if (reset || clr) begin
        s1_vld_q <= 1'b0;
        for (int j = 0; j < NP; j++) ps_q[j] <= '0;
      end else begin
        s1_vld_q <= in_valid;
        if (in_valid) ps_q <= ps_d;
      end
    end

    always_comb begin
      sum_fin = '0;
      for (int j = 0; j < NP; j++) sum_fin += ps_q[j];
      fire = s1_vld_q;
    end
  end else begin : g_nopipe
    always_comb begin
      sum_fin = '0;
      for (int i = 0; i < TAPS; i++) sum_fin += term[i];
      fire = in_valid;
    end
  end

  assign out_d = WIDTH'(sat_wrap(64'(sum_fin), WIDTH, SAT != 0));
  assign oor   = out_of_range(64'(sum_fin), WIDTH);

  // out holds between strobes; ovf is sticky until reset or clr.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (clr) begin
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= fire;
      if (fire) begin
        out_q <= out_d;
        ovf_q <= ovf_q | oor;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_h_fir_shiftadd.sv
// Bench for h_fir_shiftadd: three DUTs (PIPE0/SAT1, PIPE0/SAT0, PIPE1/SAT1)
// share one stimulus stream; a sample-history model predicts their outputs.
module tb_h_fir_shiftadd;
  localparam int W = 16;
  localparam int T = 5;

  logic CLK = 1'b0;
  logic reset, clr, in_valid, coef_we;
  logic [W-1:0] in_d;
  logic [2:0]   coef_addr;
  logic [5:0]   coef_data;
  logic [2:0][W-1:0] d_out;
  logic [2:0]   d_vld, d_ovf;

  int checks = 0;
  int failures = 0;

  // model state
  longint       hist [T];
  logic [5:0]   cf [T];
  logic [W-1:0] e_out [3];
  bit           e_vld [3];
  bit           e_ovf [3];
  bit           pend_v;
  longint       pend_s;

  always #5 CLK = ~CLK;

  h_fir_shiftadd #(.WIDTH(W), .TAPS(T), .PIPE(0), .SAT(1)) u0 (
    .CLK(CLK), .reset(reset), .clr(clr), .in(in_d), .in_valid(in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out(d_out[0]), .out_valid(d_vld[0]), .ovf(d_ovf[0]));
  h_fir_shiftadd #(.WIDTH(W), .TAPS(T), .PIPE(0), .SAT(0)) u1 (
    .CLK(CLK), .reset(reset), .clr(clr), .in(in_d), .in_valid(in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out(d_out[1]), .out_valid(d_vld[1]), .ovf(d_ovf[1]));
  h_fir_shiftadd #(.WIDTH(W), .TAPS(T), .PIPE(1), .SAT(1)) u2 (
    .CLK(CLK), .reset(reset), .clr(clr), .in(in_d), .in_valid(in_valid),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out(d_out[2]), .out_valid(d_vld[2]), .ovf(d_ovf[2]));

  // y = sum over enabled taps of +/- x[n-1-i] * 2^k, with floor for k<0
  function automatic longint model_sum();
    longint s, t, p;
    int k;
    s = 0;
    for (int i = 0; i < T; i++) begin
      if (cf[i][5]) begin
        k = cf[i][3] ? int'(cf[i][3:0]) - 16 : int'(cf[i][3:0]);
        if (k >= 0) t = hist[i] * (longint'(1) << k);
        else begin
          p = longint'(1) << (-k);
          t = hist[i] / p;
          if ((hist[i] % p) != 0 && hist[i] < 0) t = t - 1;
        end
        if (cf[i][4]) t = -t;
        s += t;
      end
    end
    return s;
  endfunction

  function automatic logic [W-1:0] conv(input longint s, input bit sat);
    if (sat && s > 32767)  return 16'h7fff;
    if (sat && s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic bit oor(input longint s);
    return (s > 32767) || (s < -32768);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < T; i++) begin hist[i] = 0; cf[i] = '0; end
    for (int u = 0; u < 3; u++) begin e_out[u] = '0; e_vld[u] = 0; e_ovf[u] = 0; end
    pend_v = 0; pend_s = 0;
  endtask

  // One clock: drive inputs, take the edge, advance the model, settle 1 time unit.
  task automatic step(input bit v, input longint x, input bit we = 0, input int a = 0,
                      input logic [5:0] cd = '0, input bit c = 0);
    longint s;
    bit acc;
    in_valid = v; in_d = x[15:0]; coef_we = we; coef_addr = a[2:0];
    coef_data = cd; clr = c;
    @(posedge CLK);
    s = model_sum();
    acc = v && !c;
    for (int u = 0; u < 2; u++) begin
      if (c) begin e_vld[u] = 0; e_ovf[u] = 0; end
      else if (acc) begin
        e_vld[u] = 1; e_out[u] = conv(s, u == 0); e_ovf[u] = e_ovf[u] | oor(s);
      end else e_vld[u] = 0;
    end
    if (c) begin e_vld[2] = 0; e_ovf[2] = 0; pend_v = 0; end
    else begin
      e_vld[2] = pend_v;
      if (pend_v) begin e_out[2] = conv(pend_s, 1); e_ovf[2] = e_ovf[2] | oor(pend_s); end
      pend_v = acc; pend_s = s;
    end
    if (c) for (int i = 0; i < T; i++) hist[i] = 0;
    else if (v) begin
      for (int i = T - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = longint'($signed(x[15:0]));
    end
    if (we && a < T) cf[a] = cd;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; clr = 0; in_valid = 0; coef_we = 0; in_d = '0; coef_addr = '0; coef_data = '0;
    model_clear();
    #12;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (d_out[u] !== 16'd0 || d_vld[u] !== 1'b0 || d_ovf[u] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d got out=%0d vld=%b ovf=%b want 0/0/0", u, d_out[u], d_vld[u], d_ovf[u]);
      end
    end
    reset = 0;
  endtask

  task automatic test_no_coef();
    int cnt[3];
    cnt = '{0, 0, 0};
    for (int n = 0; n < 11; n++) begin
      step(n < 10, 1000);
      for (int u = 0; u < 3; u++) begin
        cnt[u] += int'(d_vld[u]);
        checks++;
        if (d_vld[u] !== e_vld[u] || d_ovf[u] !== e_ovf[u] || (e_vld[u] && d_out[u] !== e_out[u])) begin
          failures++;
          $display("FAIL no_coef dut%0d got vld=%b out=%0d ovf=%b want vld=%b out=%0d ovf=%b",
                   u, d_vld[u], $signed(d_out[u]), d_ovf[u], e_vld[u], $signed(e_out[u]), e_ovf[u]);
        end
      end
    end
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (cnt[u] != 10) begin
        failures++;
        $display("FAIL no_coef_count dut%0d got %0d want 10", u, cnt[u]);
      end
    end
  endtask

  task automatic test_impulse();
    int xs[4] = '{100, 0, 0, 0};
    int ys[4] = '{0, 200, -200, 0};
    step(0, 0, 0, 0, 6'h00, 1);
    step(0, 0, 1, 0, 6'h21);  // tap0 = +x<<1
    step(0, 0, 1, 1, 6'h31);  // tap1 = -x<<1
    for (int n = 0; n < 5; n++) begin
      step(n < 4, n < 4 ? xs[n] : 0);
      if (n < 4) begin
        checks++;
        if ($signed(d_out[0]) != ys[n] || d_vld[0] !== 1'b1) begin
          failures++;
          $display("FAIL impulse[%0d] got out=%0d vld=%b want %0d/1", n, $signed(d_out[0]), d_vld[0], ys[n]);
        end
      end
      for (int u = 1; u < 3; u++) begin
        checks++;
        if (d_vld[u] !== e_vld[u] || d_ovf[u] !== e_ovf[u] || (e_vld[u] && d_out[u] !== e_out[u])) begin
          failures++;
          $display("FAIL impulse dut%0d got vld=%b out=%0d ovf=%b want vld=%b out=%0d ovf=%b",
                   u, d_vld[u], $signed(d_out[u]), d_ovf[u], e_vld[u], $signed(e_out[u]), e_ovf[u]);
        end
      end
    end
  endtask

  task automatic test_shift();
    step(0, 0, 1, 0, 6'h21);  // tap0 = x<<1
    step(0, 0, 1, 1, 6'h22);  // tap1 = x<<2
    for (int n = 0; n < 4; n++) step(1, 4);
    checks++;
    if ($signed(d_out[0]) != 24) begin
      failures++;
      $display("FAIL shift_left got %0d want 24", $signed(d_out[0]));
    end
    step(0, 0, 1, 1, 6'h2F);  // tap1 = x>>>1
    for (int n = 0; n < 4; n++) begin
      step(1, -3);
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (d_vld[u] !== e_vld[u] || d_ovf[u] !== e_ovf[u] || (e_vld[u] && d_out[u] !== e_out[u])) begin
          failures++;
          $display("FAIL shift dut%0d got vld=%b out=%0d ovf=%b want vld=%b out=%0d ovf=%b",
                   u, d_vld[u], $signed(d_out[u]), d_ovf[u], e_vld[u], $signed(e_out[u]), e_ovf[u]);
        end
      end
    end
    checks++;
    if ($signed(d_out[0]) != -8) begin
      failures++;
      $display("FAIL shift_floor got %0d want -8", $signed(d_out[0]));
    end
  endtask

  task automatic test_sat();
    step(0, 0, 0, 0, 6'h00, 1);
    step(0, 0, 1, 0, 6'h27);  // tap0 = x<<7
    step(0, 0, 1, 1, 6'h00);
    for (int n = 0; n < 3; n++) step(1, 1000);
    checks++;
    if (d_out[0] !== 16'h7fff || d_ovf[0] !== 1'b1) begin
      failures++;
      $display("FAIL sat got out=%0d ovf=%b want 32767/1", $signed(d_out[0]), d_ovf[0]);
    end
    checks++;
    if (d_out[1] !== 16'hf400 || d_ovf[1] !== 1'b1) begin
      failures++;
      $display("FAIL wrap got out=%0d ovf=%b want -3072/1", $signed(d_out[1]), d_ovf[1]);
    end
    for (int n = 0; n < 3; n++) step(1, 0);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (d_ovf[u] !== 1'b1 || d_out[u] !== e_out[u]) begin
        failures++;
        $display("FAIL ovf_sticky dut%0d got out=%0d ovf=%b want %0d/1", u, $signed(d_out[u]), d_ovf[u], $signed(e_out[u]));
      end
    end
  endtask

  task automatic test_coef_race();
    step(0, 0, 0, 0, 6'h00, 1);
    step(0, 0, 1, 0, 6'h20);  // tap0 = x
    step(0, 0, 1, 5, 6'h27);  // addr 5 out of range: ignored
    step(1, 5);
    step(1, 5, 1, 0, 6'h21);  // write coincident with in_valid
    checks++;
    if ($signed(d_out[0]) != 5) begin
      failures++;
      $display("FAIL coef_old got %0d want 5", $signed(d_out[0]));
    end
    step(1, 0);
    checks++;
    if ($signed(d_out[0]) != 10 || d_ovf[0] !== 1'b0) begin
      failures++;
      $display("FAIL coef_new got out=%0d ovf=%b want 10/0", $signed(d_out[0]), d_ovf[0]);
    end
    step(0, 0);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (d_vld[u] !== e_vld[u] || d_ovf[u] !== e_ovf[u] || d_out[u] !== e_out[u]) begin
        failures++;
        $display("FAIL coef_race dut%0d got vld=%b out=%0d ovf=%b want vld=%b out=%0d ovf=%b",
                 u, d_vld[u], $signed(d_out[u]), d_ovf[u], e_vld[u], $signed(e_out[u]), e_ovf[u]);
      end
    end
  endtask

  task automatic test_clr();
    step(0, 0, 1, 0, 6'h27);
    step(1, 1000);
    step(1, 1000);
    step(1, 1000, 0, 0, 6'h00, 1);  // clr beats in_valid
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (d_vld[u] !== 1'b0 || d_ovf[u] !== 1'b0) begin
        failures++;
        $display("FAIL clr dut%0d got vld=%b ovf=%b want 0/0", u, d_vld[u], d_ovf[u]);
      end
    end
    for (int n = 0; n < 3; n++) begin
      step(n < 2, 0);
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (d_vld[u] !== e_vld[u] || d_ovf[u] !== e_ovf[u] || (e_vld[u] && d_out[u] !== 16'd0)) begin
          failures++;
          $display("FAIL clr_after dut%0d got vld=%b out=%0d ovf=%b want vld=%b out=0 ovf=0",
                   u, d_vld[u], $signed(d_out[u]), d_ovf[u], e_vld[u]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cnt2;
    cnt2 = 0;
    step(0, 0, 0, 0, 6'h00, 1);
    step(0, 0, 1, 0, 6'h20);
    step(0, 0, 1, 2, 6'h3E);  // tap2 = -(x>>>2)
    for (int n = 0; n < 10; n++) begin
      step(n < 8, longint'($signed(16'($urandom))));
      cnt2 += int'(d_vld[2]);
      checks++;
      if (d_vld[2] !== (n >= 1 && n <= 8) || (e_vld[2] && d_out[2] !== e_out[2]) || d_ovf[2] !== e_ovf[2]) begin
        failures++;
        $display("FAIL b2b[%0d] got vld=%b out=%0d ovf=%b want vld=%b out=%0d ovf=%b",
                 n, d_vld[2], $signed(d_out[2]), d_ovf[2], (n >= 1 && n <= 8), $signed(e_out[2]), e_ovf[2]);
      end
    end
    checks++;
    if (cnt2 != 8) begin
      failures++;
      $display("FAIL b2b_count got %0d want 8", cnt2);
    end
    step(0, 0, 1, 0, 6'h27);
    for (int n = 0; n < 3; n++) step(1, 1000);
    reset = 1;  // asynchronous, between edges
    #1;
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (d_out[u] !== 16'd0 || d_vld[u] !== 1'b0 || d_ovf[u] !== 1'b0) begin
        failures++;
        $display("FAIL async_reset dut%0d got out=%0d vld=%b ovf=%b want 0/0/0", u, $signed(d_out[u]), d_vld[u], d_ovf[u]);
      end
    end
    reset = 0;
    model_clear();
    for (int n = 0; n < 3; n++) begin
      step(n == 0, 7);
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (d_vld[u] !== e_vld[u] || d_ovf[u] !== e_ovf[u] || d_out[u] !== e_out[u]) begin
          failures++;
          $display("FAIL post_reset dut%0d got vld=%b out=%0d ovf=%b want vld=%b out=%0d ovf=%b",
                   u, d_vld[u], $signed(d_out[u]), d_ovf[u], e_vld[u], $signed(e_out[u]), e_ovf[u]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, longint'($signed(16'($urandom))),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), 6'($urandom),
           $urandom_range(0, 40) == 0);
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (d_vld[u] !== e_vld[u] || d_ovf[u] !== e_ovf[u] || (e_vld[u] && d_out[u] !== e_out[u])) begin
          failures++;
          $display("FAIL random[%0d] dut%0d got vld=%b out=%0d ovf=%b want vld=%b out=%0d ovf=%b",
                   n, u, d_vld[u], $signed(d_out[u]), d_ovf[u], e_vld[u], $signed(e_out[u]), e_ovf[u]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_coef();
    test_impulse();
    test_shift();
    test_sat();
    test_coef_race();
    test_clr();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
